// File: rtl/acc_control_fsm_pkg.sv
// Shared encodings for the accumulator control sequencer: states, opcodes,
// ALU function selects and accumulator source selects.
package acc_control_fsm_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_BZ   = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_LDI  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_NAND = 2'b01;
  localparam logic [1:0] ALU_BR   = 2'b10;
  localparam logic [1:0] ALU_SLT  = 2'b11;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_REG = 2'b01;
  localparam logic [1:0] SRC_IMM = 2'b10;

  function automatic logic [2:0] opcodeOf(input logic [7:0] instr);
    return instr[7:5];
  endfunction

endpackage

// File: rtl/acc_control_fsm_decode.sv
// Combinational decode of IR plus state into datapath controls; strobes
// only ever fire in EXEC so IR changes cannot glitch the datapath.
module acc_decode
  import acc_control_fsm_pkg::*;
(
  input  state_t      state,
  input  logic [7:0]  ir,
  output logic [1:0]  aluControl,
  output logic [1:0]  accSrc,
  output logic        accWrite,
  output logic        regWrite,
  output logic [2:0]  regAddr,
  output logic [7:0]  immOut
);

  assign regAddr = ir[2:0];
  assign immOut  = {3'b000, ir[4:0]};

  always_comb begin
    aluControl = ALU_ADD;
    accSrc     = SRC_ALU;
    accWrite   = 1'b0;
    regWrite   = 1'b0;
    if (state == S_EXEC) begin
      case (opcodeOf(ir))
        OP_ADD:  accWrite = 1'b1;
        OP_NAND: begin
          aluControl = ALU_NAND;
          accWrite   = 1'b1;
        end
        OP_SLT: begin
          aluControl = ALU_SLT;
          accWrite   = 1'b1;
        end
        OP_BZ:   aluControl = ALU_BR;
        OP_LD: begin
          accSrc   = SRC_REG;
          accWrite = 1'b1;
        end
        OP_ST:   regWrite = 1'b1;
        OP_LDI: begin
          accSrc   = SRC_IMM;
          accWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/acc_control_fsm.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator datapath.
// Owns PC, IR and the retired-instruction counter.
module acc_control_fsm
  import acc_control_fsm_pkg::*;
#(
  parameter int PC_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             imemReq,
  output logic [PC_W-1:0]  imemAddr,
  input  logic [7:0]       imemData,
  input  logic             imemValid,
  input  logic             accZero,
  output logic [1:0]       aluControl,
  output logic [2:0]       regAddr,
  output logic             regWrite,
  output logic             accWrite,
  output logic [1:0]       accSrc,
  output logic [7:0]       immOut,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic [CNT_W-1:0] instrCount,
  output state_t           dbgState
);

  // Handshake: imemReq stays high for every FETCH cycle with imemAddr = pc;
  // the word is captured on the first cycle imemValid is seen high in FETCH.

  state_t          state;
  logic [7:0]      ir;
  logic [PC_W-1:0] brTarget;
  logic [PC_W-1:0] pcNext;

  assign brTarget = PC_W'(ir[4:0]);
  assign pcNext   = pc + PC_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      instrCount <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_FETCH;
        S_FETCH: begin
          if (imemValid) begin
            ir    <= imemData;
            state <= S_DECODE;
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          if (opcodeOf(ir) == OP_HALT) begin
            state <= S_HALT;
          end else begin
            instrCount <= instrCount + CNT_W'(1);
            state      <= S_FETCH;
            if (opcodeOf(ir) == OP_BZ && accZero) pc <= brTarget;
            else                                  pc <= pcNext;
          end
        end
        S_HALT: begin
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imemReq  = (state == S_FETCH);
  assign imemAddr = pc;
  assign halted   = (state == S_HALT);
  assign dbgState = state;

  acc_decode uDecode (
    .state      (state),
    .ir         (ir),
    .aluControl (aluControl),
    .accSrc     (accSrc),
    .accWrite   (accWrite),
    .regWrite   (regWrite),
    .regAddr    (regAddr),
    .immOut     (immOut)
  );

endmodule

// File: tb/tb_acc_control_fsm.sv
// Bench for acc_control_fsm: directed instruction table, randomized program
// against an instruction-level reference model, and reset/halt corner cases.
module tb_acc_control_fsm;
  import acc_control_fsm_pkg::*;

  localparam int PC_W  = 5;
  localparam int CNT_W = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             start;
  logic             imemReq;
  logic [PC_W-1:0]  imemAddr;
  logic [7:0]       imemData;
  logic             imemValid;
  logic             accZero;
  logic [1:0]       aluControl;
  logic [2:0]       regAddr;
  logic             regWrite;
  logic             accWrite;
  logic [1:0]       accSrc;
  logic [7:0]       immOut;
  logic [PC_W-1:0]  pc;
  logic             halted;
  logic [CNT_W-1:0] instrCount;
  state_t           dbgState;

  acc_control_fsm #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemData(imemData),
    .imemValid(imemValid), .accZero(accZero),
    .aluControl(aluControl), .regAddr(regAddr), .regWrite(regWrite),
    .accWrite(accWrite), .accSrc(accSrc), .immOut(immOut),
    .pc(pc), .halted(halted), .instrCount(instrCount), .dbgState(dbgState)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  int expPc = 0;
  int expCnt = 0;
  bit expHalted = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] instr;
    int         waits;
    bit         zero;
    bit         noise;
    logic [1:0] eAlu;
    logic [1:0] eSrc;
    bit         eAccW;
    bit         eRegW;
  } vec_t;

  typedef struct {
    logic [1:0] alu;
    logic [1:0] src;
    bit         accW;
    bit         regW;
  } ctl_t;

  // Expected EXEC controls straight from the opcode table.
  function automatic ctl_t refExec(input logic [7:0] instr);
    ctl_t c;
    c = '{alu: 2'b00, src: 2'b00, accW: 1'b0, regW: 1'b0};
    case (instr[7:5])
      3'd0: c.accW = 1;
      3'd1: begin c.alu = 2'b01; c.accW = 1; end
      3'd2: c.alu = 2'b10;
      3'd3: begin c.alu = 2'b11; c.accW = 1; end
      3'd4: begin c.src = 2'b01; c.accW = 1; end
      3'd5: c.regW = 1;
      3'd6: begin c.src = 2'b10; c.accW = 1; end
      default: ;
    endcase
    return c;
  endfunction

  // Drives one full fetch/decode/execute; entered and left #1 after a posedge.
  task automatic runInstr(input vec_t v);
    for (int w = 0; w < v.waits; w++) begin
      imemValid = 1'b0;
      imemData  = 8'($urandom);
      check("wait_req", imemReq, 1);
      check("wait_addr", imemAddr, expPc);
      check("wait_strobes", {accWrite, regWrite}, 0);
      tick();
    end
    imemValid = 1'b1;
    imemData  = v.instr;
    accZero   = ~v.zero;
    check("fetch_req", imemReq, 1);
    check("fetch_addr", imemAddr, expPc);
    tick();
    // DECODE
    imemValid = v.noise;
    imemData  = 8'($urandom);
    start     = v.noise;
    check("dec_regaddr", regAddr, v.instr[2:0]);
    check("dec_imm", immOut, {3'b000, v.instr[4:0]});
    check("dec_strobes", {accWrite, regWrite, aluControl}, 0);
    check("dec_req", imemReq, 0);
    tick();
    // EXEC
    accZero  = v.zero;
    imemData = 8'($urandom);
    check("exec_alu", aluControl, v.eAlu);
    check("exec_src", accSrc, v.eSrc);
    check("exec_accw", accWrite, v.eAccW);
    check("exec_regw", regWrite, v.eRegW);
    check("exec_regaddr", regAddr, v.instr[2:0]);
    check("exec_imm", immOut, {3'b000, v.instr[4:0]});
    tick();
    start     = 1'b0;
    imemValid = 1'b0;
    accZero   = 1'($urandom);
    if (v.instr[7:5] == 3'd7) begin
      expHalted = 1;
    end else begin
      expCnt = (expCnt + 1) % (1 << CNT_W);
      if (v.instr[7:5] == 3'd2 && v.zero) expPc = v.instr[4:0] % (1 << PC_W);
      else                                expPc = (expPc + 1) % (1 << PC_W);
    end
    check("post_pc", pc, expPc);
    check("post_cnt", instrCount, expCnt);
    check("post_halted", halted, expHalted);
    check("post_req", imemReq, !expHalted);
    if (!expHalted) check("post_addr", imemAddr, expPc);
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, "_req"}, imemReq, 0);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_cnt"}, instrCount, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_ctl"}, {accWrite, regWrite, aluControl, accSrc}, 0);
  endtask

  vec_t tbl[$];
  vec_t v;
  ctl_t c;

  initial begin
    reset = 1'b1; start = 1'b0; imemValid = 1'b0; imemData = 8'h00; accZero = 1'b0;
    // directed program: instr, waits, zero, noise, alu, src, accW, regW
    tbl.push_back('{8'h03, 0, 0, 0, 2'b00, 2'b00, 1, 0}); // ADD r3   pc0
    tbl.push_back('{8'hC5, 2, 0, 0, 2'b00, 2'b10, 1, 0}); // LDI 5    pc1
    tbl.push_back('{8'hA2, 2, 0, 0, 2'b00, 2'b00, 0, 1}); // ST r2    pc2
    tbl.push_back('{8'h21, 1, 0, 0, 2'b01, 2'b00, 1, 0}); // NAND r1  pc3
    tbl.push_back('{8'h49, 0, 1, 0, 2'b10, 2'b00, 0, 0}); // BZ 9 taken   pc4
    tbl.push_back('{8'h44, 1, 1, 1, 2'b10, 2'b00, 0, 0}); // BZ 4 taken   pc9
    tbl.push_back('{8'h49, 0, 0, 1, 2'b10, 2'b00, 0, 0}); // BZ 9 not taken pc4
    tbl.push_back('{8'h7B, 0, 0, 1, 2'b11, 2'b00, 1, 0}); // SLT r3   pc5
    tbl.push_back('{8'h85, 3, 0, 0, 2'b00, 2'b01, 1, 0}); // LD r5    pc6

    tick(); tick();
    checkIdleOutputs("reset");
    reset = 1'b0;
    imemValid = 1'b1;  // ignored outside FETCH
    imemData  = 8'hFF;
    tick(); tick();
    imemValid = 1'b0;
    checkIdleOutputs("idle_hold");

    start = 1'b1; tick(); start = 1'b0;
    foreach (tbl[i]) runInstr(tbl[i]);
    check("pre_reset_pc", pc, 7);

    // asynchronous reset while waiting in FETCH
    #2 reset = 1'b1;
    #1 checkIdleOutputs("async_reset");
    tick();
    reset = 1'b0;
    expPc = 0; expCnt = 0; expHalted = 0;
    tick();
    checkIdleOutputs("post_reset_idle");

    // randomized program, HALT excluded
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 60; n++) begin
      v.instr = {3'($urandom_range(0, 6)), 5'($urandom_range(0, 31))};
      v.waits = $urandom_range(0, 3);
      v.zero  = 1'($urandom_range(0, 1));
      v.noise = 1'($urandom_range(0, 1));
      c = refExec(v.instr);
      v.eAlu = c.alu; v.eSrc = c.src; v.eAccW = c.accW; v.eRegW = c.regW;
      runInstr(v);
    end

    // pc wrap: branch to 31 then a plain ADD
    runInstr('{8'h5F, 0, 1, 0, 2'b10, 2'b00, 0, 0});
    check("at_31", pc, 31);
    runInstr('{8'h00, 1, 0, 0, 2'b00, 2'b00, 1, 0});
    check("wrapped", pc, 0);

    // HALT with start/imemValid noise in DECODE/EXEC
    runInstr('{8'hE0, 0, 0, 1, 2'b00, 2'b00, 0, 0});
    imemValid = 1'b1;
    repeat (3) tick();
    imemValid = 1'b0;
    check("halt_hold", halted, 1);
    check("halt_cnt", instrCount, expCnt);
    check("halt_req", imemReq, 0);
    start = 1'b1; tick(); start = 1'b0;
    expPc = 0; expHalted = 0;
    check("restart_halted", halted, 0);
    check("restart_pc", pc, 0);
    check("restart_req", imemReq, 1);
    check("restart_cnt", instrCount, expCnt);
    runInstr('{8'h03, 0, 0, 0, 2'b00, 2'b00, 1, 0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
